// File: rtl/definitions.sv
// Shared TileLink-UL opcode encodings and response-buffer sizing for the SRAM slave.
package definitions;

  // Channel A opcodes this slave understands; everything else is answered with an error.
  typedef enum logic [2:0] {
    PUT_FULL    = 3'd0,
    PUT_PARTIAL = 3'd1,
    GET         = 3'd4
  } tl_a_opcode_t;

  // Channel D opcodes; kept apart from channel A because the encodings overlap.
  typedef enum logic [2:0] {
    ACCESS_ACK      = 3'd0,
    ACCESS_ACK_DATA = 3'd1
  } tl_d_opcode_t;

  // Response FIFO depth. Together with the S1 register this bounds in-flight requests.
  localparam int unsigned RESP_DEPTH = 3;

  // True for both Put flavours; they are serviced identically.
  function automatic logic is_put_op(input logic [2:0] op);
    return (op == PUT_FULL) || (op == PUT_PARTIAL);
  endfunction

  function automatic logic is_get_op(input logic [2:0] op);
    return op == GET;
  endfunction

endpackage

// File: rtl/tl_resp_fifo.sv
// Small in-order FIFO used to queue channel D responses. Head is read
// combinationally so the D fields sit still until the entry is popped.
module tl_resp_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PW'(1);
  endfunction

  assign full_o  = (count_reg == CW'(DEPTH));
  assign empty_o = (count_reg == '0);
  assign count_o = count_reg;
  assign data_o  = mem[rd_ptr_reg];

  // A pop frees the head slot on the same edge, so a push into a full FIFO is legal then.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= data_i;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= next_ptr(wr_ptr_reg);
      end
      if (do_pop) begin
        rd_ptr_reg <= next_ptr(rd_ptr_reg);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/tl_ul_sram_slave.sv
// TileLink-UL slave backed by a word-addressed SRAM. Requests are decoded and
// error-checked on channel A, the array is accessed at acceptance, results are
// held one cycle in S1 and then queued in an in-order response FIFO for channel D.
module tl_ul_sram_slave
  import definitions::*;
#(
  parameter int unsigned W       = 4,
  parameter int unsigned A       = 32,
  parameter int unsigned Z       = 32,
  parameter int unsigned O       = 1,
  parameter int unsigned I       = 1,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned SINK_ID = 0
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           a_valid_i,
  output logic           a_ready_o,
  input  logic [2:0]     a_opcode_i,
  input  logic [2:0]     a_param_i,
  input  logic [Z-1:0]   a_size_i,
  input  logic [O-1:0]   a_source_i,
  input  logic [A-1:0]   a_address_i,
  input  logic [W-1:0]   a_mask_i,
  input  logic [8*W-1:0] a_data_i,
  output logic           d_valid_o,
  input  logic           d_ready_i,
  output logic [2:0]     d_opcode_o,
  output logic [1:0]     d_param_o,
  output logic [Z-1:0]   d_size_o,
  output logic [O-1:0]   d_source_o,
  output logic [I-1:0]   d_sink_o,
  output logic [8*W-1:0] d_data_o,
  output logic           d_error_o
);

  localparam int unsigned LW = $clog2(W);
  localparam int unsigned LD = $clog2(DEPTH);
  localparam int unsigned AW = LW + LD;
  localparam int unsigned DW = 8 * W;
  localparam int unsigned CW = $clog2(RESP_DEPTH + 1);
  localparam int unsigned EW = 3 + Z + O + 1 + DW;
  localparam logic [CW:0] OCC_LIMIT = (CW + 1)'(RESP_DEPTH);

  // Request decode
  logic          is_get;
  logic          is_put;
  logic          addr_oor;
  logic          size_err;
  logic          misaligned;
  logic          req_err;
  logic          accept;
  logic          wr_en;
  logic          rd_en;
  logic [LD-1:0] word_idx;
  logic [W-1:0]  lane_we;

  // Array and S1 stage
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_data_reg;
  logic          s1_valid_reg;
  tl_d_opcode_t  s1_opcode_reg;
  logic [Z-1:0]  s1_size_reg;
  logic [O-1:0]  s1_source_reg;
  logic          s1_error_reg;
  logic [DW-1:0] s1_data;

  // Response FIFO
  logic [EW-1:0] push_entry;
  logic [EW-1:0] head_entry;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   occupancy;
  logic [2:0]    head_opcode;
  logic [Z-1:0]  head_size;
  logic [O-1:0]  head_source;
  logic          head_error;
  logic [DW-1:0] head_data;

  // Inputs with no effect on behaviour are folded here to keep them visibly consumed.
  logic unused_bits;
  assign unused_bits = ^{a_param_i, fifo_full};

  assign is_get   = is_get_op(a_opcode_i);
  assign is_put   = is_put_op(a_opcode_i);
  assign word_idx = a_address_i[AW-1:LW];
  assign size_err = (a_size_i > Z'(LW));

  // Any address bit above the array span makes the request out of range.
  generate
    if (AW < A) begin : g_oor
      assign addr_oor = |a_address_i[A-1:AW];
    end else begin : g_no_oor
      assign addr_oor = 1'b0;
    end
  endgenerate

  // Misaligned when any byte-offset bit below 2^size is set.
  always_comb begin
    misaligned = 1'b0;
    for (int i = 0; i < LW; i++) begin
      if ((Z'(i) < a_size_i) && a_address_i[i]) begin
        misaligned = 1'b1;
      end
    end
  end

  assign req_err = addr_oor | size_err | misaligned | ~(is_get | is_put);

  // Occupancy covers every request past channel A, so the FIFO can never overflow.
  // Only registered state feeds a_ready_o; d_ready_i has no combinational path here.
  assign occupancy = {{CW{1'b0}}, s1_valid_reg} + {1'b0, fifo_count};
  assign a_ready_o = rst_ni & (occupancy < OCC_LIMIT);
  assign accept    = a_valid_i & a_ready_o;
  assign wr_en     = accept & is_put & ~req_err;
  assign rd_en     = accept & is_get & ~req_err;

  // Per-lane write enables; PutFull and PutPartial both honour the mask as given.
  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_lane_we
      assign lane_we[gi] = wr_en & a_mask_i[gi];
    end
  endgenerate

  // SRAM: byte-lane writes and registered read at acceptance. A Get accepted the
  // cycle after a Put sees the committed word, so no forwarding is needed.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < W; k++) begin
      if (lane_we[k]) begin
        mem[word_idx][8*k +: 8] <= a_data_i[8*k +: 8];
      end
    end
    if (rd_en) begin
      rd_data_reg <= mem[word_idx];
    end
  end

  // S1 register: response metadata for the request accepted on the previous edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_reg  <= 1'b0;
      s1_opcode_reg <= ACCESS_ACK;
      s1_size_reg   <= '0;
      s1_source_reg <= '0;
      s1_error_reg  <= 1'b0;
    end else begin
      s1_valid_reg <= accept;
      if (accept) begin
        s1_opcode_reg <= is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
        s1_size_reg   <= a_size_i;
        s1_source_reg <= a_source_i;
        s1_error_reg  <= req_err;
      end
    end
  end

  // Only successful Gets carry array data; rd_data_reg is stale for anything else.
  assign s1_data    = (s1_error_reg || (s1_opcode_reg != ACCESS_ACK_DATA)) ? '0 : rd_data_reg;
  assign push_entry = {s1_opcode_reg, s1_size_reg, s1_source_reg, s1_error_reg, s1_data};

  tl_resp_fifo #(
    .WIDTH (EW),
    .DEPTH (RESP_DEPTH),
    .CW    (CW)
  ) u_resp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (s1_valid_reg),
    .data_i  (push_entry),
    .pop_i   (d_ready_i),
    .data_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign {head_opcode, head_size, head_source, head_error, head_data} = head_entry;

  // D fields are forced to zero whenever no response is presented.
  assign d_valid_o  = ~fifo_empty;
  assign d_opcode_o = d_valid_o ? head_opcode : '0;
  assign d_size_o   = d_valid_o ? head_size   : '0;
  assign d_source_o = d_valid_o ? head_source : '0;
  assign d_error_o  = d_valid_o ? head_error  : 1'b0;
  assign d_data_o   = d_valid_o ? head_data   : '0;
  assign d_param_o  = 2'b00;
  assign d_sink_o   = I'(SINK_ID);

endmodule
